// File: rtl/arcade_input_ctrl.sv
// Arcade control aggregation: PS/2 key latches and joysticks merged into per-player
// {up,down,left,right,fire,start,coin}, with autofire, one-shot coin pulses and DIP capture.

module arcade_input_ctrl_coin #(
   parameter int COIN_PULSE = 4096
) (
   input  logic clk_sys,
   input  logic reset_n,
   input  logic coin_raw,
   output logic pulse
);
   localparam int CW = (COIN_PULSE > 1) ? $clog2(COIN_PULSE) : 1;

   typedef enum logic [1:0] {IDLE, PULSE, HOLD} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic            coin_prev;

   // coin_prev tracks raw even in reset so a held coin cannot retrigger on release
   always_ff @(posedge clk_sys) begin
      coin_prev <= coin_raw;
      if (!reset_n) begin
         state <= IDLE;
         cnt   <= '0;
         pulse <= 1'b0;
      end else begin
         case (state)
            IDLE: if (coin_raw && !coin_prev) begin
               state <= PULSE;
               cnt   <= '0;
               pulse <= 1'b1;
            end
            PULSE: if (cnt == CW'(COIN_PULSE - 1)) begin
               pulse <= 1'b0;
               state <= coin_raw ? HOLD : IDLE;
            end else begin
               cnt <= cnt + 1'b1;
            end
            HOLD: if (!coin_raw) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

module arcade_input_ctrl #(
   parameter int NUM_PLAYERS  = 2,
   parameter int DIP_BYTES    = 2,
   parameter int COIN_PULSE   = 4096,
   parameter int AUTOFIRE_DIV = 1600000
) (
   input  logic                   clk_sys,
   input  logic                   reset_n,
   input  logic [10:0]            ps2_key,
   input  logic [15:0]            joystick_0,
   input  logic [15:0]            joystick_1,
   input  logic                   ioctl_wr,
   input  logic [7:0]             ioctl_index,
   input  logic [24:0]            ioctl_addr,
   input  logic [7:0]             ioctl_dout,
   input  logic                   autofire_en,
   output logic [6:0]             udlrtsc_p1,
   output logic [6:0]             udlrtsc_p2,
   output logic [8*DIP_BYTES-1:0] dipsw,
   output logic                   dip_valid
);
   localparam int AFW = $clog2(AUTOFIRE_DIV);
   localparam int K_U1 = 0,  K_D1 = 1,  K_L1 = 2,  K_R1 = 3,  K_F1 = 4,  K_S1 = 5,  K_C1 = 6;
   localparam int K_U2 = 7,  K_D2 = 8,  K_L2 = 9,  K_R2 = 10, K_F2 = 11, K_S2 = 12, K_C2 = 13;
   localparam logic P2_ON = (NUM_PLAYERS == 2);

   logic        key_tog;
   logic        kbd_event;
   logic [13:0] keys, keys_d;

   assign kbd_event = ps2_key[10] != key_tog;

   // outputs are built from the next latch state so a key event shows up after one edge
   always_comb begin
      keys_d = keys;
      if (!reset_n) begin
         keys_d = '0;
      end else if (kbd_event) begin
         if      (ps2_key[7:0] == 8'h75) keys_d[K_U1] = ps2_key[9];
         else if (ps2_key[7:0] == 8'h72) keys_d[K_D1] = ps2_key[9];
         else if (ps2_key[7:0] == 8'h6B) keys_d[K_L1] = ps2_key[9];
         else if (ps2_key[7:0] == 8'h74) keys_d[K_R1] = ps2_key[9];
         else begin
            case (ps2_key[8:0])
               9'h014: keys_d[K_F1] = ps2_key[9];
               9'h016: keys_d[K_S1] = ps2_key[9];
               9'h02E: keys_d[K_C1] = ps2_key[9];
               9'h005: begin keys_d[K_S1] = ps2_key[9]; keys_d[K_C1] = ps2_key[9]; end
               9'h02D: keys_d[K_U2] = ps2_key[9];
               9'h02B: keys_d[K_D2] = ps2_key[9];
               9'h023: keys_d[K_L2] = ps2_key[9];
               9'h034: keys_d[K_R2] = ps2_key[9];
               9'h01C: keys_d[K_F2] = ps2_key[9];
               9'h01E: keys_d[K_S2] = ps2_key[9];
               9'h036: keys_d[K_C2] = ps2_key[9];
               9'h006: begin keys_d[K_S2] = ps2_key[9]; keys_d[K_C2] = ps2_key[9]; end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      keys    <= keys_d;
      key_tog <= ps2_key[10];
   end

   logic [4:0] dir1, dir2;
   logic       start1, start2;
   logic [1:0] coin_raw, coin_pulse;

   assign dir1 = {keys_d[K_U1] | joystick_0[3], keys_d[K_D1] | joystick_0[2],
                  keys_d[K_L1] | joystick_0[1], keys_d[K_R1] | joystick_0[0],
                  keys_d[K_F1] | joystick_0[4]};
   assign dir2 = {5{P2_ON}} &
                 {keys_d[K_U2] | joystick_1[3], keys_d[K_D2] | joystick_1[2],
                  keys_d[K_L2] | joystick_1[1], keys_d[K_R2] | joystick_1[0],
                  keys_d[K_F2] | joystick_1[4]};
   assign start1      = keys_d[K_S1] | joystick_0[6] | joystick_1[6];
   assign start2      = keys_d[K_S2] | joystick_0[7] | joystick_1[7];
   assign coin_raw[0] = keys_d[K_C1] | joystick_0[8];
   assign coin_raw[1] = P2_ON & (keys_d[K_C2] | joystick_1[8]);

   logic unused_joy;
   assign unused_joy = ^{joystick_0[15:9], joystick_0[5], joystick_1[15:9], joystick_1[5]};

   logic [AFW-1:0] af_cnt;
   logic           af_phase;
   logic           fire_gate;

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         af_cnt   <= '0;
         af_phase <= 1'b0;
      end else if (af_cnt == AFW'(AUTOFIRE_DIV - 1)) begin
         af_cnt   <= '0;
         af_phase <= ~af_phase;
      end else begin
         af_cnt <= af_cnt + 1'b1;
      end
   end

   assign fire_gate = af_phase | ~autofire_en;

   logic [5:0] pad1, pad2;

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         pad1 <= '0;
         pad2 <= '0;
      end else begin
         pad1 <= {dir1[4:1], dir1[0] & fire_gate, start1};
         pad2 <= P2_ON ? {dir2[4:1], dir2[0] & fire_gate, start2} : 6'b0;
      end
   end

   genvar g;
   for (g = 0; g < 2; g++) begin : g_coin
      arcade_input_ctrl_coin #(.COIN_PULSE(COIN_PULSE)) u_coin (
         .clk_sys  (clk_sys),
         .reset_n  (reset_n),
         .coin_raw (coin_raw[g]),
         .pulse    (coin_pulse[g])
      );
   end

   assign udlrtsc_p1 = {pad1, coin_pulse[0]};
   assign udlrtsc_p2 = {pad2, coin_pulse[1] & P2_ON};

   // DIP bytes arrive while the core is held in reset, so they ignore reset_n
   logic [8*DIP_BYTES-1:0] dip_q = '0;
   logic                   dip_v = 1'b0;
   logic                   dip_hit;

   assign dip_hit = ioctl_wr && (ioctl_index == 8'd254) && (ioctl_addr[24:3] == '0) &&
                    (int'(ioctl_addr[2:0]) < DIP_BYTES);

   always_ff @(posedge clk_sys) begin
      if (dip_hit) begin
         for (int k = 0; k < DIP_BYTES; k++)
            if (ioctl_addr[2:0] == 3'(k)) dip_q[8*(DIP_BYTES-1-k) +: 8] <= ioctl_dout;
         dip_v <= 1'b1;
      end
   end

   assign dipsw     = dip_q;
   assign dip_valid = dip_v;
endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Scoreboard bench: two configurations driven in lockstep, expected outputs queued
// by a behavioural model and compared by a separate monitor each cycle.

module tb_arcade_input_ctrl;
   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [10:0] ps2;
   logic [15:0] j0, j1;
   logic        wr, af;
   logic [7:0]  idx, dout;
   logic [24:0] addr;

   logic [6:0]  a_p1, a_p2, b_p1, b_p2;
   logic [15:0] a_dip;
   logic [23:0] b_dip;
   logic        a_dv, b_dv;

   arcade_input_ctrl #(.NUM_PLAYERS(2), .DIP_BYTES(2), .COIN_PULSE(4096), .AUTOFIRE_DIV(4)) dut_a (
      .clk_sys(clk), .reset_n(rst_n), .ps2_key(ps2), .joystick_0(j0), .joystick_1(j1),
      .ioctl_wr(wr), .ioctl_index(idx), .ioctl_addr(addr), .ioctl_dout(dout),
      .autofire_en(af), .udlrtsc_p1(a_p1), .udlrtsc_p2(a_p2), .dipsw(a_dip), .dip_valid(a_dv));

   arcade_input_ctrl #(.NUM_PLAYERS(1), .DIP_BYTES(3), .COIN_PULSE(5), .AUTOFIRE_DIV(3)) dut_b (
      .clk_sys(clk), .reset_n(rst_n), .ps2_key(ps2), .joystick_0(j0), .joystick_1(j1),
      .ioctl_wr(wr), .ioctl_index(idx), .ioctl_addr(addr), .ioctl_dout(dout),
      .autofire_en(af), .udlrtsc_p1(b_p1), .udlrtsc_p2(b_p2), .dipsw(b_dip), .dip_valid(b_dv));

   typedef struct packed {
      logic [6:0]  p1;
      logic [6:0]  p2;
      logic [63:0] dip;
      logic        dv;
   } exp_t;

   exp_t qa[$], qb[$];
   int   checks = 0, errors = 0;

   // model state, index [dut] or [dut][player]
   logic [13:0] m_keys[2];
   logic        m_tog[2];
   logic        m_prev[2][2];
   logic        m_wait[2][2];
   int          m_left[2][2];
   int          m_k[2];
   logic [7:0]  m_dip[2][8];
   logic        m_dv[2];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic coin_step(int d, int p, int width, logic r);
      if (m_left[d][p] > 0) begin
         m_left[d][p]--;
         if (m_left[d][p] == 0) m_wait[d][p] = r;
      end else if (m_wait[d][p]) begin
         if (!r) m_wait[d][p] = 1'b0;
      end else if (r && !m_prev[d][p]) begin
         m_left[d][p] = width;
      end
      m_prev[d][p] = r;
      return m_left[d][p] > 0;
   endfunction

   function automatic exp_t model_step(int d);
      int          np  = (d == 0) ? 2 : 1;
      int          db  = (d == 0) ? 2 : 3;
      int          cw  = (d == 0) ? 4096 : 5;
      int          div = (d == 0) ? 4 : 3;
      exp_t        e;
      logic [13:0] kk;
      logic        pr, ph, c1, c2, s1, s2, cr1, cr2;
      kk = m_keys[d];
      if (!rst_n) begin
         kk = '0;
         m_tog[d] = ps2[10];
      end else if (ps2[10] != m_tog[d]) begin
         m_tog[d] = ps2[10];
         pr = ps2[9];
         if      (ps2[7:0] == 8'h75) kk[0] = pr;
         else if (ps2[7:0] == 8'h72) kk[1] = pr;
         else if (ps2[7:0] == 8'h6B) kk[2] = pr;
         else if (ps2[7:0] == 8'h74) kk[3] = pr;
         else case (ps2[8:0])
            9'h014: kk[4] = pr;
            9'h016: kk[5] = pr;
            9'h02E: kk[6] = pr;
            9'h005: begin kk[5] = pr; kk[6] = pr; end
            9'h02D: kk[7] = pr;
            9'h02B: kk[8] = pr;
            9'h023: kk[9] = pr;
            9'h034: kk[10] = pr;
            9'h01C: kk[11] = pr;
            9'h01E: kk[12] = pr;
            9'h036: kk[13] = pr;
            9'h006: begin kk[12] = pr; kk[13] = pr; end
            default: ;
         endcase
      end
      m_keys[d] = kk;
      s1  = kk[5] | j0[6] | j1[6];
      s2  = kk[12] | j0[7] | j1[7];
      cr1 = kk[6] | j0[8];
      cr2 = (np == 2) && (kk[13] | j1[8]);
      e = '0;
      if (!rst_n) begin
         m_k[d] = 0;
         for (int p = 0; p < 2; p++) begin m_left[d][p] = 0; m_wait[d][p] = 1'b0; end
         m_prev[d][0] = cr1;
         m_prev[d][1] = cr2;
      end else begin
         ph = ((m_k[d] / div) % 2) == 1;
         m_k[d]++;
         c1 = coin_step(d, 0, cw, cr1);
         c2 = coin_step(d, 1, cw, cr2);
         e.p1 = {kk[0] | j0[3], kk[1] | j0[2], kk[2] | j0[1], kk[3] | j0[0],
                 (kk[4] | j0[4]) & (ph | ~af), s1, c1};
         if (np == 2)
            e.p2 = {kk[7] | j1[3], kk[8] | j1[2], kk[9] | j1[1], kk[10] | j1[0],
                    (kk[11] | j1[4]) & (ph | ~af), s2, c2};
      end
      if (wr && idx == 8'd254 && addr[24:3] == 22'd0 && int'(addr[2:0]) < db) begin
         m_dip[d][addr[2:0]] = dout;
         m_dv[d] = 1'b1;
      end
      for (int k = 0; k < db; k++) e.dip[8*(db-1-k) +: 8] = m_dip[d][k];
      e.dv = m_dv[d];
      return e;
   endfunction

   task automatic tick();
      qa.push_back(model_step(0));
      qb.push_back(model_step(1));
      @(negedge clk);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic key(input logic pressed, input logic [8:0] code);
      ps2 = {~ps2[10], pressed, code};
      tick();
   endtask

   task automatic dip_wr(input logic [7:0] ix, input logic [24:0] ad, input logic [7:0] v);
      wr = 1'b1; idx = ix; addr = ad; dout = v;
      tick();
      wr = 1'b0;
   endtask

   // monitor: pops one expectation per edge, also gathers pulse/duty statistics
   logic cnt_en = 1'b0, last_coin = 1'b0;
   int   cnt_coin_hi, cnt_coin_rise, cnt_fire_hi;
   always @(posedge clk) begin
      exp_t ea, eb;
      #1;
      if (qa.size() > 0) begin
         ea = qa.pop_front();
         chk("a_p1", 64'(a_p1), 64'(ea.p1));
         chk("a_p2", 64'(a_p2), 64'(ea.p2));
         chk("a_dip", {47'd0, a_dv, a_dip}, {47'd0, ea.dv, ea.dip[15:0]});
      end
      if (qb.size() > 0) begin
         eb = qb.pop_front();
         chk("b_p1", 64'(b_p1), 64'(eb.p1));
         chk("b_p2", 64'(b_p2), 64'(eb.p2));
         chk("b_dip", {39'd0, b_dv, b_dip}, {39'd0, eb.dv, eb.dip[23:0]});
      end
      if (cnt_en) begin
         if (a_p1[0]) cnt_coin_hi++;
         if (a_p1[0] && !last_coin) cnt_coin_rise++;
         if (a_p1[2]) cnt_fire_hi++;
      end
      last_coin = a_p1[0];
   end

   logic [8:0] codes[20];

   initial begin
      codes = '{9'h175, 9'h075, 9'h172, 9'h16B, 9'h074, 9'h014, 9'h016, 9'h02E, 9'h005, 9'h02D,
                9'h02B, 9'h023, 9'h034, 9'h01C, 9'h01E, 9'h036, 9'h006, 9'h114, 9'h12D, 9'h0AA};
      for (int d = 0; d < 2; d++) begin
         m_dv[d] = 1'b0;
         for (int k = 0; k < 8; k++) m_dip[d][k] = 8'h00;
      end
      rst_n = 1'b0; ps2 = '0; j0 = '0; j1 = '0; wr = 1'b0; idx = '0; addr = '0; dout = '0; af = 1'b0;

      // reset with ps2 toggling: no event may leak out on release
      ticks(2);
      ps2 = 11'h475;
      ticks(2);
      chk("reset_p1", 64'(a_p1), 64'd0);
      chk("reset_dip", {47'd0, a_dv, a_dip}, 64'd0);
      rst_n = 1'b1;
      ticks(3);
      chk("no_evt_on_release", 64'(a_p1[6]), 64'd0);

      key(1'b1, 9'h175);
      chk("up_press", 64'(a_p1[6]), 64'd1);
      key(1'b0, 9'h175);
      chk("up_release", 64'(a_p1[6]), 64'd0);

      key(1'b1, 9'h005);
      chk("f1_start_coin", 64'(a_p1[1:0]), 64'd3);
      key(1'b0, 9'h005);
      ticks(3);

      // DIP capture, including same-cycle keyboard event and ignored addresses
      ps2 = {~ps2[10], 1'b1, 9'h02D};
      dip_wr(8'd254, 25'd0, 8'hA5);
      chk("kbd_and_dip", 64'(a_p2[6]), 64'd1);
      dip_wr(8'd254, 25'd1, 8'h3C);
      dip_wr(8'd254, 25'd2, 8'h77);
      dip_wr(8'd254, 25'd8, 8'hFF);
      dip_wr(8'd253, 25'd0, 8'h11);
      key(1'b0, 9'h02D);
      chk("dip_a", {47'd0, a_dv, a_dip}, {47'd0, 1'b1, 16'hA53C});
      chk("dip_b", {39'd0, b_dv, b_dip}, {39'd0, 1'b1, 24'hA53C77});
      rst_n = 1'b0;
      ticks(2);
      rst_n = 1'b1;
      ticks(1);
      chk("dip_after_reset", {47'd0, a_dv, a_dip}, {47'd0, 1'b1, 16'hA53C});

      // autofire: DIV=4 gives an 8-cycle square wave
      j0[4] = 1'b1; af = 1'b1;
      ticks(3);
      cnt_fire_hi = 0; cnt_en = 1'b1;
      ticks(16);
      cnt_en = 1'b0;
      chk("autofire_duty", 64'(cnt_fire_hi), 64'd8);
      af = 1'b0;
      ticks(1);
      cnt_fire_hi = 0; cnt_en = 1'b1;
      ticks(16);
      cnt_en = 1'b0;
      chk("autofire_off", 64'(cnt_fire_hi), 64'd16);
      j0[4] = 1'b0;

      // held coin: a single 4096-cycle pulse
      rst_n = 1'b0; ticks(1); rst_n = 1'b1; ticks(2);
      cnt_coin_hi = 0; cnt_coin_rise = 0; cnt_en = 1'b1;
      j0[8] = 1'b1;
      ticks(10000);
      j0[8] = 1'b0;
      ticks(4);
      cnt_en = 1'b0;
      chk("coin_width", 64'(cnt_coin_hi), 64'd4096);
      chk("coin_once", 64'(cnt_coin_rise), 64'd1);

      // reset mid-pulse with the coin still held: no retrigger
      j0[8] = 1'b1;
      ticks(50);
      rst_n = 1'b0; ticks(2); rst_n = 1'b1;
      ticks(1);
      cnt_coin_hi = 0; cnt_en = 1'b1;
      ticks(100);
      cnt_en = 1'b0;
      chk("coin_no_retrigger", 64'(cnt_coin_hi), 64'd0);
      j0[8] = 1'b0;
      ticks(2);

      // single-player config ignores joystick_1 except start buttons
      j1 = 16'h01FF;
      ticks(2);
      chk("np1_p2_zero", 64'(b_p2), 64'd0);
      chk("np1_start1", 64'(b_p1[1]), 64'd1);
      chk("np1_coin1", 64'(b_p1[0]), 64'd0);
      j1 = '0;
      ticks(4100);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0)
            ps2 = {~ps2[10], 1'($urandom_range(0, 1)), codes[$urandom_range(0, 19)]};
         if ($urandom_range(0, 7) == 0) j0[$urandom_range(0, 15)] ^= 1'b1;
         if ($urandom_range(0, 7) == 0) j1[$urandom_range(0, 15)] ^= 1'b1;
         if ($urandom_range(0, 63) == 0) af = ~af;
         rst_n = ($urandom_range(0, 499) != 0);
         wr   = ($urandom_range(0, 15) == 0);
         idx  = ($urandom_range(0, 3) == 0) ? 8'd253 : 8'd254;
         addr = ($urandom_range(0, 5) == 0) ? 25'(8 * $urandom_range(1, 4)) : 25'($urandom_range(0, 7));
         dout = 8'($urandom);
         tick();
      end
      wr = 1'b0; rst_n = 1'b1;
      ticks(2);
      @(posedge clk);
      #3;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
